// File: rtl/psg_channels_if.sv
// -----------------------------------------------------------------------------
// psg_channels_if
// Decoded register-write bus between the byte-decoding stage (master) and the
// psg_channels register file / waveform core (slave).
//   adress    [2:0]  register index (0/2/4 tone period, 1/3/5 tone att,
//                    6 noise control, 7 noise att)
//   value     [9:0]  write data
//   load             one-cycle write strobe, qualifies adress/value
//   noise_rst        one-cycle LFSR reset strobe (only with load and adress 6)
// -----------------------------------------------------------------------------
interface psg_channels_if;
    logic [2:0] adress;
    logic [9:0] value;
    logic       load;
    logic       noise_rst;

    modport master (
        output adress,
        output value,
        output load,
        output noise_rst
    );

    modport slave (
        input adress,
        input value,
        input load,
        input noise_rst
    );
endinterface

// File: rtl/psg_channels.sv
// -----------------------------------------------------------------------------
// psg_channels
// Register file and waveform core of an SN76489-compatible sound generator.
// Holds the eight chip registers, divides the system clock into generator
// ticks, and produces three square-wave tones, an LFSR noise bit and four
// attenuation codes for the mixer/DAC stage.
//
// Parameters:
//   CLK_DIV      system clocks per generator tick (2..256)
// Build option:
//   PSG_NOISE_EN defined   -> noise counter, 15-bit LFSR and noise_rst built
//   PSG_NOISE_EN undefined -> noise_out_o tied 0, noise_rst ignored;
//                             registers 6/7 still writable, att3_o still updates
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          psg_channels_if.slave register-write bus
//   tone0_o..2_o square-wave outputs
//   noise_out_o  noise bit (LFSR bit 0)
//   att0_o..3_o  attenuation for tone0..2 and noise, 4'hF = silent
// -----------------------------------------------------------------------------
module psg_channels #(
    parameter int CLK_DIV = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    psg_channels_if.slave        bus,
    output logic                 tone0_o,
    output logic                 tone1_o,
    output logic                 tone2_o,
    output logic                 noise_out_o,
    output logic [3:0]           att0_o,
    output logic [3:0]           att1_o,
    output logic [3:0]           att2_o,
    output logic [3:0]           att3_o
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    // Prescaler
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_s;

    // Register file
    logic [9:0] period_q [3];
    logic [9:0] period_d [3];
    logic [3:0] att_q    [4];
    logic [3:0] att_d    [4];
    logic [2:0] nctl_q, nctl_d;

    // Tone generators
    logic [9:0] cnt_q  [3];
    logic [9:0] cnt_d  [3];
    logic       tone_q [3];
    logic       tone_d [3];

    assign tick_s = (presc_q == PRESC_MAX);

    // Prescaler next state: wraps CLK_DIV-1 -> 0, tick marks the wrap cycle
    always_comb begin
        presc_d = presc_q;
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Register-file next state: only the addressed register changes
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            period_d[i] = period_q[i];
        end
        for (int i = 0; i < 4; i++) begin
            att_d[i] = att_q[i];
        end
        nctl_d = nctl_q;
        if (bus.load) begin
            case (bus.adress)
                3'd0:    period_d[0] = bus.value;
                3'd1:    att_d[0]    = bus.value[3:0];
                3'd2:    period_d[1] = bus.value;
                3'd3:    att_d[1]    = bus.value[3:0];
                3'd4:    period_d[2] = bus.value;
                3'd5:    att_d[2]    = bus.value[3:0];
                3'd6:    nctl_d      = bus.value[2:0];
                3'd7:    att_d[3]    = bus.value[3:0];
                default: nctl_d      = nctl_q;
            endcase
        end else begin
            nctl_d = nctl_q;
        end
    end

    // Tone next state: a counter at 0 or 1 reloads from the current period
    // register, so a period written in the same cycle only lands on the next
    // reload, and a period of 0 toggles every tick just like 1
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            cnt_d[n]  = cnt_q[n];
            tone_d[n] = tone_q[n];
            if (tick_s) begin
                if (cnt_q[n] <= 10'd1) begin
                    cnt_d[n]  = period_q[n];
                    tone_d[n] = ~tone_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] - 10'd1;
                end
            end else begin
                cnt_d[n] = cnt_q[n];
            end
        end
    end

    // Prescaler, register file and tone state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            nctl_q  <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                period_q[i] <= 10'd0;
                cnt_q[i]    <= 10'd0;
                tone_q[i]   <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                att_q[i] <= 4'hF;
            end
        end else begin
            presc_q <= presc_d;
            nctl_q  <= nctl_d;
            for (int i = 0; i < 3; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
                tone_q[i]   <= tone_d[i];
            end
            for (int i = 0; i < 4; i++) begin
                att_q[i] <= att_d[i];
            end
        end
    end

    assign tone0_o = tone_q[0];
    assign tone1_o = tone_q[1];
    assign tone2_o = tone_q[2];
    assign att0_o  = att_q[0];
    assign att1_o  = att_q[1];
    assign att2_o  = att_q[2];
    assign att3_o  = att_q[3];

`ifdef PSG_NOISE_EN
    // Half-period of the internal noise toggle, in ticks
    function automatic logic [6:0] noise_reload(input logic [1:0] sel);
        logic [6:0] r;
        case (sel)
            2'd0:    r = 7'd16;
            2'd1:    r = 7'd32;
            2'd2:    r = 7'd64;
            default: r = 7'd16;
        endcase
        return r;
    endfunction

    // Bit shifted into LFSR[14]: tap x^0 ^ x^1 for white noise, x^0 alone
    // for periodic noise
    function automatic logic lfsr_fb(input logic [14:0] s, input logic white);
        logic fb;
        if (white) begin
            fb = s[0] ^ s[1];
        end else begin
            fb = s[0];
        end
        return fb;
    endfunction

    logic [6:0]  ncnt_q, ncnt_d;
    logic        ntog_q, ntog_d;
    logic [14:0] lfsr_q, lfsr_d;
    logic        noise_rst_s;
    logic        tone2_rise_s;
    logic        ntog_rise_s;
    logic        src_rise_s;

    assign noise_rst_s = bus.load && bus.noise_rst && (bus.adress == 3'd6);

    // Rising edges are detected on the cycle the source toggles 0 -> 1, so
    // the LFSR shifts on the same edge the source rises
    assign tone2_rise_s = tick_s && (cnt_q[2] <= 10'd1) && !tone_q[2];
    assign ntog_rise_s  = tick_s && (nctl_q[1:0] != 2'b11) &&
                          (ncnt_q <= 7'd1) && !ntog_q;
    assign src_rise_s   = (nctl_q[1:0] == 2'b11) ? tone2_rise_s : ntog_rise_s;

    // Noise next state: internal counter held while tone2 is the source;
    // noise_rst overrides any shift or counter step in the same cycle
    always_comb begin
        ncnt_d = ncnt_q;
        ntog_d = ntog_q;
        lfsr_d = lfsr_q;
        if (tick_s && (nctl_q[1:0] != 2'b11)) begin
            if (ncnt_q <= 7'd1) begin
                ncnt_d = noise_reload(nctl_q[1:0]);
                ntog_d = ~ntog_q;
            end else begin
                ncnt_d = ncnt_q - 7'd1;
            end
        end else begin
            ncnt_d = ncnt_q;
        end
        if (noise_rst_s) begin
            lfsr_d = 15'h4000;
            ncnt_d = 7'd0;
            ntog_d = 1'b0;
        end else if (src_rise_s) begin
            lfsr_d = {lfsr_fb(lfsr_q, nctl_q[2]), lfsr_q[14:1]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Noise counter, toggle and LFSR registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncnt_q <= 7'd0;
            ntog_q <= 1'b0;
            lfsr_q <= 15'h4000;
        end else begin
            ncnt_q <= ncnt_d;
            ntog_q <= ntog_d;
            lfsr_q <= lfsr_d;
        end
    end

    assign noise_out_o = lfsr_q[0];
`else
    // Noise control is still stored for software readback consistency but
    // drives nothing in this build
    logic unused_noise_s;
    assign unused_noise_s = ^{nctl_q, bus.noise_rst};
    assign noise_out_o    = 1'b0;
`endif

endmodule

// File: tb/tb_psg_channels.sv
// -----------------------------------------------------------------------------
// tb_psg_channels
// Self-checking bench for psg_channels (CLK_DIV = 16). A tick-level model of
// the chip registers, tone half-periods and noise LFSR runs alongside the DUT;
// a compare process checks every output on every falling edge, and directed
// sequences add hand-computed expectations for timing and LFSR values.
// Noise-specific sequences are built only when PSG_NOISE_EN is defined.
// -----------------------------------------------------------------------------
module tb_psg_channels;

    localparam int CLK_DIV = 16;

    logic       clk;
    logic       rst_n;
    logic       tone0, tone1, tone2, noise_out;
    logic [3:0] att0, att1, att2, att3;

    psg_channels_if bus ();

    psg_channels #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .tone0_o     (tone0),
        .tone1_o     (tone1),
        .tone2_o     (tone2),
        .noise_out_o (noise_out),
        .att0_o      (att0),
        .att1_o      (att1),
        .att2_o      (att2),
        .att3_o      (att3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int clk_cnt  = 0;

    // ---------------- reference model ----------------
    int m_per   [3];
    int m_att   [4];
    int m_ctl;
    int m_left  [3];   // ticks until the next toggle of each tone
    int m_tone  [3];
    int m_nleft;       // ticks until the next internal noise toggle
    int m_ntog;
    int m_lfsr;
    int m_shifts;
    int m_cyc;         // clocks since reset release

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at clk %0d",
                     name, act, act, exp, exp, clk_cnt);
        end
    endtask

    initial forever begin
        @(posedge clk);
        clk_cnt++;
    end

    initial forever begin
        int  old_ctl;
        bit  tick;
        bit  rise;
        int  fb;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_per[i] = 0; m_left[i] = 1; m_tone[i] = 0;
            end
            for (int i = 0; i < 4; i++) m_att[i] = 15;
            m_ctl = 0; m_nleft = 1; m_ntog = 0; m_lfsr = 'h4000; m_cyc = 0;
        end else begin
            old_ctl = m_ctl;
            rise    = 1'b0;
            tick    = ((m_cyc % CLK_DIV) == CLK_DIV - 1);
            m_cyc++;
            if (tick) begin
                for (int n = 0; n < 3; n++) begin
                    m_left[n]--;
                    if (m_left[n] == 0) begin
                        m_tone[n] ^= 1;
                        m_left[n] = (m_per[n] > 0) ? m_per[n] : 1;
                        if (n == 2 && m_tone[2] == 1 && (old_ctl & 3) == 3) rise = 1'b1;
                    end
                end
            end
`ifdef PSG_NOISE_EN
            if (tick && (old_ctl & 3) != 3) begin
                m_nleft--;
                if (m_nleft == 0) begin
                    m_ntog ^= 1;
                    m_nleft = 16 << (old_ctl & 3);
                    if (m_ntog == 1) rise = 1'b1;
                end
            end
            if (bus.load && bus.adress == 3'd6 && bus.noise_rst) begin
                m_lfsr = 'h4000; m_nleft = 1; m_ntog = 0;
            end else if (rise) begin
                fb = (old_ctl & 4) ? ((m_lfsr ^ (m_lfsr >> 1)) & 1) : (m_lfsr & 1);
                m_lfsr = (m_lfsr >> 1) | (fb << 14);
                m_shifts++;
            end
`endif
            if (bus.load) begin
                case (int'(bus.adress))
                    0, 2, 4: m_per[bus.adress / 2] = int'(bus.value);
                    1, 3, 5: m_att[bus.adress / 2] = int'(bus.value) & 15;
                    6:       m_ctl = int'(bus.value) & 7;
                    default: m_att[3] = int'(bus.value) & 15;
                endcase
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("tone0", int'(tone0), m_tone[0]);
            check("tone1", int'(tone1), m_tone[1]);
            check("tone2", int'(tone2), m_tone[2]);
            check("att0",  int'(att0),  m_att[0]);
            check("att1",  int'(att1),  m_att[1]);
            check("att2",  int'(att2),  m_att[2]);
            check("att3",  int'(att3),  m_att[3]);
`ifdef PSG_NOISE_EN
            check("noise_out", int'(noise_out), m_lfsr & 1);
`else
            check("noise_out", int'(noise_out), 0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int adr, input int val, input bit nrst);
        bus.adress    = 3'(adr);
        bus.value     = 10'(val);
        bus.load      = 1'b1;
        bus.noise_rst = nrst;
        @(negedge clk);
        bus.load      = 1'b0;
        bus.noise_rst = 1'b0;
    endtask

    function automatic logic dut_tone(input int n);
        logic t;
        case (n)
            0:       t = tone0;
            1:       t = tone1;
            default: t = tone2;
        endcase
        return t;
    endfunction

    task automatic wait_tone(input int n, input int budget, output int t);
        logic prev;
        prev = dut_tone(n);
        t    = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut_tone(n) != prev) begin
                t = clk_cnt;
                return;
            end
        end
        check($sformatf("tone%0d_timeout", n), 0, 1);
    endtask

    task automatic wait_shift(input int budget);
        int s;
        s = m_shifts;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_shifts != s) return;
        end
        check("lfsr_shift_timeout", 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0, t1, t2, t3, t4;
        bus.adress = 3'd0; bus.value = 10'd0; bus.load = 1'b0; bus.noise_rst = 1'b0;
        m_shifts = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tone0", int'(tone0), 0);
        check("rst_tone1", int'(tone1), 0);
        check("rst_tone2", int'(tone2), 0);
        check("rst_noise", int'(noise_out), 0);
        check("rst_att0", int'(att0), 15);
        check("rst_att1", int'(att1), 15);
        check("rst_att2", int'(att2), 15);
        check("rst_att3", int'(att3), 15);

        // First tick CLK_DIV clocks after release
        rst_n = 1'b1;
        c0 = clk_cnt;
        wait_tone(0, 100, t1);
        check("first_tick", t1 - c0, CLK_DIV);

        // Period 5 -> half-period 80 clocks
        wr(0, 5, 1'b0);
        wait_tone(0, 400, t1);
        wait_tone(0, 400, t2);
        wait_tone(0, 400, t3);
        check("p5_half_a", t2 - t1, 80);
        check("p5_half_b", t3 - t2, 80);

        // Period 0 behaves as period 1 -> half-period 16 clocks
        wr(0, 0, 1'b0);
        wait_tone(0, 400, t1);
        wait_tone(0, 100, t2);
        wait_tone(0, 100, t3);
        check("p0_half_a", t2 - t1, 16);
        check("p0_half_b", t3 - t2, 16);

        // Attenuation write: one-clock latency, other channels untouched
        wr(3, 'h007, 1'b0);
        check("att1_write", int'(att1), 7);
        check("att0_keep", int'(att0), 15);
        check("att2_keep", int'(att2), 15);
        check("att3_keep", int'(att3), 15);
        wr(7, 'h3F5, 1'b0);
        check("att3_write", int'(att3), 5);
        wr(5, 'h002, 1'b0);
        wr(1, 'h00C, 1'b0);   // back-to-back writes
        check("att2_b2b", int'(att2), 2);
        check("att0_b2b", int'(att0), 12);

        // Tone1 period change mid-count: 8 -> 2
        wr(2, 8, 1'b0);
        wait_tone(1, 200, t1);
        wait_tone(1, 400, t2);
        check("t1_p8_half", t2 - t1, 128);
        wr(2, 2, 1'b0);
        wait_tone(1, 400, t3);
        wait_tone(1, 400, t4);
        check("t1_finish_old", t3 - t2, 128);
        check("t1_new_half", t4 - t3, 32);

`ifdef PSG_NOISE_EN
        // White noise from reset seed
        wr(6, 'b100, 1'b1);
        check("lfsr_seed", m_lfsr, 'h4000);
        wait_shift(100);
        check("lfsr_shift1", m_lfsr, 'h2000);
        wait_shift(600);
        check("lfsr_shift2", m_lfsr, 'h1000);
        wait_shift(600);
        check("lfsr_shift3", m_lfsr, 'h0800);

        // noise_rst without adress 6 is ignored
        c0 = m_lfsr;
        wr(7, 'h00F, 1'b1);
        check("nrst_ignored", m_lfsr, c0);

        // tone2 as shift source: one shift per tone2 rising edge
        wr(4, 3, 1'b0);
        wr(6, 'b011, 1'b0);
        repeat (200) @(negedge clk);
        begin
            int s0, rises;
            logic prev;
            s0 = m_shifts; rises = 0; prev = tone2;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (tone2 && !prev) rises++;
                prev = tone2;
            end
            check("t2_src_shifts", m_shifts - s0, rises);
            check("t2_src_rises", int'(rises >= 10), 1);
        end

        // Periodic noise: sequence of length 15
        wr(6, 'b000, 1'b1);
        check("per_seed", m_lfsr, 'h4000);
        for (int k = 1; k <= 15; k++) begin
            wait_shift(600);
            if (k < 15) check($sformatf("per_step%0d", k), int'(m_lfsr == 'h4000), 0);
        end
        check("per_len15", m_lfsr, 'h4000);
`else
        wr(6, 'b100, 1'b1);
        wr(7, 'h009, 1'b0);
        check("att3_no_noise", int'(att3), 9);
        repeat (300) @(negedge clk);
        check("noise_tied", int'(noise_out), 0);
`endif

        // Mid-operation reset returns everything to reset values at once
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_tone1", int'(tone1), 0);
        check("mrst_att1", int'(att1), 15);
        check("mrst_att3", int'(att3), 15);
        check("mrst_noise", int'(noise_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = clk_cnt;
        wait_tone(2, 100, t1);
        check("mrst_first_tick", t1 - c0, CLK_DIV);
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
